alu_issue: RTL and testbench
============================

# alu_issue

Execute-stage front end for the RISC Mini core: accepts decoded micro-ops on a valid/ready handshake and registers their operands. It drives the existing combinational `alu`, captures `alu_out`/`alu_cc` into an output register, and resolves branches into a next-PC. It sits between decode/register-read and writeback/fetch-redirect. It is a two-stage pipeline with full backpressure, flush, and sticky status flags.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `RD_W`, 5, destination register index width

Ports:
- `clk` in 1: single clock; all state updates on its rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `in_valid` in 1: micro-op offered
- `in_ready` out 1: micro-op accepted when `in_valid && in_ready`
- `in_opcode` in 7: `{funct, type}`, same encoding as the `alu` opcode
- `in_a`, `in_b` in XLEN: operands
- `in_rd` in RD_W: destination register
- `in_pc` in XLEN: PC of the op
- `in_imm` in XLEN: branch offset, sign-extended
- `out_valid` out 1: result held
- `out_ready` in 1: downstream accepts
- `out_result` out XLEN: registered `alu_out`
- `out_cc` out 4: registered `alu_cc`
- `out_rd` out RD_W: destination register
- `out_wb_en` out 1: 1 for legal R_TYPE ops
- `out_br_taken` out 1: B_TYPE op with `alu_cc[0]=1`
- `out_next_pc` out XLEN: branch target or fall-through PC
- `out_illegal` out 1: type is neither R_TYPE nor B_TYPE, or funct is not a legal code for that type
- `flush` in 1: kill all in-flight ops
- `flag_clr` in 1: clear sticky flags
- `sticky_ovf`, `sticky_brw` out 1: sticky copies of `cc[1]` and `cc[2]`
- `cnt_ops`, `cnt_taken` out 32: performance counters (see Configuration)

## Operation
- Stage S1 (operand register) holds `s1_valid`, opcode, a, b, rd, pc and imm. The `alu` input is driven only from S1.
- Stage S2 (output register) holds every `out_*` field. S2 loads from S1 and the `alu` outputs when S1 advances.
- Per-stage control:
  - `s2_free = !out_valid || out_ready`
  - `s1_adv = s1_valid && s2_free`
  - `in_ready = (!s1_valid || s1_adv) && !flush`
- Decode at S2 load:
  - R_TYPE legal: `out_wb_en=1`, `out_br_taken=0`, `out_next_pc=pc+4`.
  - B_TYPE legal: `out_wb_en=0`, `out_br_taken=alu_cc[0]`, `out_next_pc = taken ? pc+imm : pc+4`.
  - Illegal: `out_illegal=1`, `out_wb_en=0`, `out_br_taken=0`, `out_next_pc=pc+4`. `out_result` and `out_cc` still pass the `alu` values.
- All PC arithmetic is modulo 2^XLEN; wrap-around is silent.
- `flush`: S1 and S2 valids clear on the next edge and no input is accepted that cycle. A transfer completing in that same cycle (`out_valid && out_ready`) still counts as delivered.
- Sticky flags:
  - On each S2 load of a legal op, `sticky_ovf |= alu_cc[1]` and `sticky_brw |= alu_cc[2]`.
  - `flag_clr` clears both. If a set and `flag_clr` happen in the same cycle, the set wins.
- Ops leave in acceptance order; none are dropped or duplicated.

## Timing
- Reset values: all valids 0, `in_ready` 0 while `rst_n`=0 and 1 after release, all `out_*` 0, sticky flags 0, counters 0.
- Reset asserted mid-operation discards all in-flight ops immediately (asynchronous).
- Latency is 2 cycles: an op accepted at edge N appears with `out_valid=1` after edge N+1 when unstalled.
- Throughput is 1 op/cycle with `out_ready` held high.
- With `out_ready` low, the pipeline holds 2 ops and `in_ready` drops in the cycle after S1 fills.
- `out_*` fields are stable while `out_valid && !out_ready`.
- `in_ready` is combinational from `out_ready` and `flush`. No other combinational input-to-output paths exist.

## Configuration
- `ALU_ISSUE_PERF_EN` defined:
  - `cnt_ops` increments on every output transfer.
  - `cnt_taken` increments on every transfer with `out_br_taken=1`.
  - Both wrap at 2^32 and clear on reset; flush does not clear them.
- `ALU_ISSUE_PERF_EN` undefined: both ports are tied to 0 and no counter registers exist.

## Structure
- Shared package `alu_issue_pkg` holds:
  - `XLEN`, `RD_W` defaults
  - a typedef'd packed struct for the S1 record (opcode, a, b, rd, pc, imm)
  - the legal-funct lists per type, built from the existing `ADD`…`NOT`, `BEQ`…`BGE`, `R_TYPE` and `B_TYPE` defines
- One sub-module: the existing `alu`, instantiated unchanged. Decode and next-PC logic are inline.

## Test plan
- ADD, a=5, b=7, rd=3, out_ready=1 -> 2 cycles later `out_result=12`, `cc=0000`, `wb_en=1`, `rd=3`, `next_pc=pc+4`.
- ADD, a=0x7FFFFFFF, b=1 -> `result=0x80000000`, `cc[1]=1`, `sticky_ovf=1`. `sticky_ovf` persists until `flag_clr`; with `flag_clr` and a new overflow in the same cycle it stays 1.
- Branches with pc=0x100, imm=0x20:
  - BEQ a=b=3 -> `br_taken=1`, `next_pc=0x120`
  - BNE a=b=3 -> `br_taken=0`, `next_pc=0x104`
  - BLT a=-1, b=1 -> taken
  - BEQ taken with pc=0xFFFFFFF0, imm=0x20 -> `next_pc=0x10`
- Backpressure: issue ADD 1+1, ADD 2+2, ADD 3+3 back-to-back with out_ready=0 -> `in_ready` drops after two accepts. On releasing out_ready, results 2, 4, 6 come out in order; `cnt_ops=3` with `ALU_ISSUE_PERF_EN`, 0 without.
- Flush with both stages full -> next cycle `out_valid=0`, no results emitted, `in_ready=1`. An op offered in the flush cycle is not accepted.
- Illegal funct in a B_TYPE op -> `out_illegal=1`, `wb_en=0`, `br_taken=0`. Separately, `rst_n` pulsed low with 2 ops in flight -> all outputs 0 immediately, no stale result after release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu_issue execute front end and its alu.
// Opcode layout is {funct[3:0], type[2:0]}. Legal funct sets per type are
// derived from the ADD..NOT and BEQ..BGE codes below.
`ifndef R_TYPE
`define R_TYPE 3'd1
`endif
`ifndef B_TYPE
`define B_TYPE 3'd2
`endif
`ifndef ADD
`define ADD 4'd0
`endif
`ifndef SUB
`define SUB 4'd1
`endif
`ifndef AND
`define AND 4'd2
`endif
`ifndef OR
`define OR  4'd3
`endif
`ifndef XOR
`define XOR 4'd4
`endif
`ifndef NOT
`define NOT 4'd5
`endif
`ifndef BEQ
`define BEQ 4'd0
`endif
`ifndef BNE
`define BNE 4'd1
`endif
`ifndef BLT
`define BLT 4'd2
`endif
`ifndef BGE
`define BGE 4'd3
`endif

package alu_issue_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_RD_W = 5;

    localparam logic [2:0] TYPE_R = `R_TYPE;
    localparam logic [2:0] TYPE_B = `B_TYPE;

    localparam logic [3:0] FN_ADD = `ADD;
    localparam logic [3:0] FN_SUB = `SUB;
    localparam logic [3:0] FN_AND = `AND;
    localparam logic [3:0] FN_OR  = `OR;
    localparam logic [3:0] FN_XOR = `XOR;
    localparam logic [3:0] FN_NOT = `NOT;
    localparam logic [3:0] FN_BEQ = `BEQ;
    localparam logic [3:0] FN_BNE = `BNE;
    localparam logic [3:0] FN_BLT = `BLT;
    localparam logic [3:0] FN_BGE = `BGE;

    // One bit per funct code that is legal for the given type
    localparam logic [15:0] R_LEGAL = (16'd1 << FN_ADD) | (16'd1 << FN_SUB) |
                                      (16'd1 << FN_AND) | (16'd1 << FN_OR)  |
                                      (16'd1 << FN_XOR) | (16'd1 << FN_NOT);
    localparam logic [15:0] B_LEGAL = (16'd1 << FN_BEQ) | (16'd1 << FN_BNE) |
                                      (16'd1 << FN_BLT) | (16'd1 << FN_BGE);

    // Operand-stage record
    typedef struct packed {
        logic [6:0]          opcode;
        logic [DEF_XLEN-1:0] a;
        logic [DEF_XLEN-1:0] b;
        logic [DEF_RD_W-1:0] rd;
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_XLEN-1:0] imm;
    } s1_rec_t;

    function automatic logic op_legal(input logic [6:0] opcode);
        logic [15:0] mask;
        mask = '0;
        if (opcode[2:0] == TYPE_R) mask = R_LEGAL;
        else if (opcode[2:0] == TYPE_B) mask = B_LEGAL;
        return mask[opcode[6:3]];
    endfunction

endpackage

// File: rtl/alu_issue_alu.sv
// Combinational alu. cc = {negative, borrow, signed overflow, branch condition}.
// Illegal opcodes produce a zero result and zero flags.
module alu
    import alu_issue_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [6:0]      opcode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] alu_out,
    output logic [3:0]      alu_cc
);

    logic [2:0]      op_type;
    logic [3:0]      funct;
    logic [XLEN-1:0] sum;
    logic [XLEN:0]   diff;
    logic            add_ovf;
    logic            sub_ovf;
    logic            cond;
    logic            ovf;
    logic            brw;

    assign op_type = opcode[2:0];
    assign funct   = opcode[6:3];
    assign sum     = a + b;
    assign diff    = {1'b0, a} - {1'b0, b};
    assign add_ovf = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
    assign sub_ovf = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);

    // Result and flag selection by type and funct
    always_comb begin
        alu_out = '0;
        cond    = 1'b0;
        ovf     = 1'b0;
        brw     = 1'b0;
        case (op_type)
            TYPE_R: begin
                case (funct)
                    FN_ADD: begin alu_out = sum; ovf = add_ovf; end
                    FN_SUB: begin alu_out = diff[XLEN-1:0]; ovf = sub_ovf; brw = diff[XLEN]; end
                    FN_AND: alu_out = a & b;
                    FN_OR:  alu_out = a | b;
                    FN_XOR: alu_out = a ^ b;
                    FN_NOT: alu_out = ~a;
                    default: alu_out = '0;
                endcase
            end
            TYPE_B: begin
                if (op_legal(opcode)) begin
                    alu_out = diff[XLEN-1:0];
                    ovf     = sub_ovf;
                    brw     = diff[XLEN];
                end
                case (funct)
                    FN_BEQ:  cond = (a == b);
                    FN_BNE:  cond = (a != b);
                    FN_BLT:  cond = ($signed(a) <  $signed(b));
                    FN_BGE:  cond = ($signed(a) >= $signed(b));
                    default: cond = 1'b0;
                endcase
            end
            default: alu_out = '0;
        endcase
    end

    assign alu_cc = {alu_out[XLEN-1], brw, ovf, cond};

endmodule

// File: rtl/alu_issue.sv
// Two-stage execute front end: S1 operand register feeding the alu, S2 output
// register with decode and branch resolution, sticky overflow/borrow flags.
// Optional feature macro: ALU_ISSUE_PERF_EN enables cnt_ops / cnt_taken.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int RD_W = DEF_RD_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [RD_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [3:0]      out_cc,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wb_en,
    output logic            out_br_taken,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_illegal,
    input  logic            flush,
    input  logic            flag_clr,
    output logic            sticky_ovf,
    output logic            sticky_brw,
    output logic [31:0]     cnt_ops,
    output logic [31:0]     cnt_taken
);

    s1_rec_t         s1_reg;
    logic            s1_valid_reg;
    logic            out_valid_reg;
    logic [XLEN-1:0] out_result_reg;
    logic [3:0]      out_cc_reg;
    logic [RD_W-1:0] out_rd_reg;
    logic            out_wb_en_reg;
    logic            out_br_taken_reg;
    logic [XLEN-1:0] out_next_pc_reg;
    logic            out_illegal_reg;
    logic            sticky_ovf_reg;
    logic            sticky_brw_reg;

    logic [XLEN-1:0] alu_out;
    logic [3:0]      alu_cc;
    logic            s2_free;
    logic            s1_adv;
    logic            accept;
    logic            s2_load;
    logic            s1_legal;
    logic            wb_en_next;
    logic            br_taken_next;
    logic [XLEN-1:0] next_pc_next;

    alu #(.XLEN(XLEN)) u_alu (
        .opcode  (s1_reg.opcode),
        .a       (s1_reg.a),
        .b       (s1_reg.b),
        .alu_out (alu_out),
        .alu_cc  (alu_cc)
    );

    assign s2_free  = !out_valid_reg || out_ready;
    assign s1_adv   = s1_valid_reg && s2_free;
    // rst_n term keeps in_ready low for the whole reset window
    assign in_ready = rst_n && (!s1_valid_reg || s1_adv) && !flush;
    assign accept   = in_valid && in_ready;
    assign s2_load  = s1_adv && !flush;

    // Decode and branch resolution of the op sitting in S1
    always_comb begin
        s1_legal      = op_legal(s1_reg.opcode);
        wb_en_next    = s1_legal && (s1_reg.opcode[2:0] == TYPE_R);
        br_taken_next = s1_legal && (s1_reg.opcode[2:0] == TYPE_B) && alu_cc[0];
        next_pc_next  = br_taken_next ? (s1_reg.pc + s1_reg.imm) : (s1_reg.pc + XLEN'(4));
    end

    // S1: capture accepted op, drain when it advances, kill on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_reg       <= '0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_reg       <= '{opcode: in_opcode, a: in_a, b: in_b, rd: in_rd, pc: in_pc, imm: in_imm};
        end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // S2: load from S1 and the alu, hold while stalled, kill on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg    <= 1'b0;
            out_result_reg   <= '0;
            out_cc_reg       <= '0;
            out_rd_reg       <= '0;
            out_wb_en_reg    <= 1'b0;
            out_br_taken_reg <= 1'b0;
            out_next_pc_reg  <= '0;
            out_illegal_reg  <= 1'b0;
        end else if (flush) begin
            out_valid_reg    <= 1'b0;
        end else if (s1_adv) begin
            out_valid_reg    <= 1'b1;
            out_result_reg   <= alu_out;
            out_cc_reg       <= alu_cc;
            out_rd_reg       <= s1_reg.rd;
            out_wb_en_reg    <= wb_en_next;
            out_br_taken_reg <= br_taken_next;
            out_next_pc_reg  <= next_pc_next;
            out_illegal_reg  <= !s1_legal;
        end else if (out_ready) begin
            out_valid_reg    <= 1'b0;
        end
    end

    // Sticky flags: a set in the same cycle as flag_clr wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf_reg <= 1'b0;
            sticky_brw_reg <= 1'b0;
        end else begin
            sticky_ovf_reg <= (sticky_ovf_reg && !flag_clr) || (s2_load && s1_legal && alu_cc[1]);
            sticky_brw_reg <= (sticky_brw_reg && !flag_clr) || (s2_load && s1_legal && alu_cc[2]);
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] cnt_ops_reg;
    logic [31:0] cnt_taken_reg;
    logic        xfer;

    assign xfer = out_valid_reg && out_ready;

    // Delivered-op counters; a transfer during flush still counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ops_reg   <= '0;
            cnt_taken_reg <= '0;
        end else if (xfer) begin
            cnt_ops_reg   <= cnt_ops_reg + 32'd1;
            if (out_br_taken_reg) cnt_taken_reg <= cnt_taken_reg + 32'd1;
        end
    end

    assign cnt_ops   = cnt_ops_reg;
    assign cnt_taken = cnt_taken_reg;
`else
    assign cnt_ops   = '0;
    assign cnt_taken = '0;
`endif

    assign out_valid    = out_valid_reg;
    assign out_result   = out_result_reg;
    assign out_cc       = out_cc_reg;
    assign out_rd       = out_rd_reg;
    assign out_wb_en    = out_wb_en_reg;
    assign out_br_taken = out_br_taken_reg;
    assign out_next_pc  = out_next_pc_reg;
    assign out_illegal  = out_illegal_reg;
    assign sticky_ovf   = sticky_ovf_reg;
    assign sticky_brw   = sticky_brw_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a reference model.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [31:0] in_a = '0, in_b = '0, in_pc = '0, in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result, out_next_pc;
    logic [3:0]  out_cc;
    logic [4:0]  out_rd;
    logic        out_wb_en, out_br_taken, out_illegal;
    logic        flush = 1'b0, flag_clr = 1'b0;
    logic        sticky_ovf, sticky_brw;
    logic [31:0] cnt_ops, cnt_taken;

    int vectors = 0;
    int miscompares = 0;
    int seen_ops = 0;
    int seen_taken = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_pc(in_pc), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_cc(out_cc), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .out_br_taken(out_br_taken), .out_next_pc(out_next_pc), .out_illegal(out_illegal),
        .flush(flush), .flag_clr(flag_clr), .sticky_ovf(sticky_ovf), .sticky_brw(sticky_brw),
        .cnt_ops(cnt_ops), .cnt_taken(cnt_taken)
    );

    // Delivered transfers as observed on the output handshake
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_ops   <= 0;
            seen_taken <= 0;
        end else if (out_valid && out_ready) begin
            seen_ops <= seen_ops + 1;
            if (out_br_taken) seen_taken <= seen_taken + 1;
        end
    end

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic [31:0] pc, imm;
        logic [75:0] exp;
    } vec_t;

    function automatic logic [6:0] mk(input logic [3:0] f, input logic [2:0] t);
        return {f, t};
    endfunction

    function automatic logic [75:0] pk(input logic [31:0] r, input logic [3:0] cc, input logic [4:0] rd,
                                       input logic wb, input logic tk, input logic [31:0] npc, input logic ill);
        return {r, cc, rd, wb, tk, npc, ill};
    endfunction

    function automatic logic [75:0] dut_bundle();
        return {out_result, out_cc, out_rd, out_wb_en, out_br_taken, out_next_pc, out_illegal};
    endfunction

    // Reference model: plain arithmetic on the ISA meaning of each op
    function automatic logic [75:0] model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm);
        int unsigned f = op[6:3];
        int unsigned t = op[2:0];
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint hi = 2147483647;
        longint lo = -hi - 1;
        longint s;
        logic [31:0] r = '0;
        logic ovf = 0, brw = 0, cond = 0;
        logic is_r = (t == 1) && (f <= 5);
        logic is_b = (t == 2) && (f <= 3);
        if (is_r) begin
            case (f)
                0: begin r = a + b; s = sa + sb; ovf = (s > hi) || (s < lo); end
                1: begin r = a - b; s = sa - sb; ovf = (s > hi) || (s < lo); brw = (a < b); end
                2: r = a & b;
                3: r = a | b;
                4: r = a ^ b;
                default: r = ~a;
            endcase
        end
        if (t == 2) begin
            case (f)
                0: cond = (a == b);
                1: cond = (a != b);
                2: cond = (sa < sb);
                3: cond = (sa >= sb);
                default: cond = 0;
            endcase
        end
        if (is_b) begin
            r = a - b; s = sa - sb; ovf = (s > hi) || (s < lo); brw = (a < b);
        end
        return pk(r, {r[31], brw, ovf, cond}, rd, is_r, is_b && cond,
                  (is_b && cond) ? pc + imm : pc + 32'd4, !(is_r || is_b));
    endfunction

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic drive_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm);
        in_opcode = op; in_a = a; in_b = b; in_rd = rd; in_pc = pc; in_imm = imm;
    endtask

    // One op through an idle pipeline; checks latency and all output fields
    task automatic run_one(input vec_t v);
        int lat = 0;
        int n = 0;
        bit got = 0;
        @(negedge clk);
        drive_op(v.op, v.a, v.b, v.rd, v.pc, v.imm);
        in_valid = 1; out_ready = 1;
        #1;
        while (!in_ready && n < 10) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            in_valid = 0;
            lat++;
            #1;
            if (out_valid) got = 1;
        end
        check({v.name, "_latency"}, 76'(lat), 76'd2);
        check(v.name, dut_bundle(), v.exp);
    endtask

    // Offer ADD k+k (k = idx+1) with out_ready low until 'target' ops are held
    task automatic fill(input int target, output int accepted);
        int idx = 0;
        out_ready = 0;
        for (int c = 0; c < 6; c++) begin
            if (idx < target) begin
                drive_op(mk(FN_ADD, TYPE_R), idx + 1, idx + 1, 5'(idx), 32'h200, 0);
                in_valid = 1;
            end else in_valid = 0;
            #1;
            if (in_valid && in_ready) idx++;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 0;
        accepted = idx;
    endtask

    vec_t tbl[9];
    logic [75:0] exp_q[$];

    initial begin
        int idx, got, hits, acc;
        logic [31:0] res[3];
        logic [6:0] rop;
        logic [31:0] ra, rb, rpc, rimm;
        logic [4:0] rrd;
        bit pending;

        tbl[0] = '{"add_5_7",   mk(FN_ADD, TYPE_R), 5, 7, 3, 32'h40, 0,
                   pk(12, 4'b0000, 3, 1, 0, 32'h44, 0)};
        tbl[1] = '{"add_ovf",   mk(FN_ADD, TYPE_R), 32'h7FFFFFFF, 1, 1, 32'h40, 0,
                   pk(32'h80000000, 4'b1010, 1, 1, 0, 32'h44, 0)};
        tbl[2] = '{"sub_brw",   mk(FN_SUB, TYPE_R), 3, 5, 2, 32'h40, 0,
                   pk(32'hFFFFFFFE, 4'b1100, 2, 1, 0, 32'h44, 0)};
        tbl[3] = '{"beq_taken", mk(FN_BEQ, TYPE_B), 3, 3, 0, 32'h100, 32'h20,
                   pk(0, 4'b0001, 0, 0, 1, 32'h120, 0)};
        tbl[4] = '{"bne_not",   mk(FN_BNE, TYPE_B), 3, 3, 0, 32'h100, 32'h20,
                   pk(0, 4'b0000, 0, 0, 0, 32'h104, 0)};
        tbl[5] = '{"blt_taken", mk(FN_BLT, TYPE_B), 32'hFFFFFFFF, 1, 0, 32'h100, 32'h20,
                   pk(32'hFFFFFFFE, 4'b1001, 0, 0, 1, 32'h120, 0)};
        tbl[6] = '{"beq_wrap",  mk(FN_BEQ, TYPE_B), 5, 5, 0, 32'hFFFFFFF0, 32'h20,
                   pk(0, 4'b0001, 0, 0, 1, 32'h10, 0)};
        tbl[7] = '{"b_ill_fn",  mk(4'd9, TYPE_B), 4, 4, 7, 32'h100, 32'h20,
                   pk(0, 4'b0000, 7, 0, 0, 32'h104, 1)};
        tbl[8] = '{"ill_type",  mk(FN_ADD, 3'd5), 4, 4, 9, 32'h300, 0,
                   pk(0, 4'b0000, 9, 0, 0, 32'h304, 1)};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctl", 76'({in_ready, out_valid, sticky_ovf, sticky_brw}), 76'd0);
        check("reset_out", dut_bundle(), 76'd0);
        check("reset_cnt", 76'({cnt_ops, cnt_taken}), 76'd0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("ready_after_reset", 76'(in_ready), 76'd1);

        // Directed vector table
        for (int i = 0; i < 9; i++) run_one(tbl[i]);

        // Sticky flags
        @(negedge clk); out_ready = 1;
        #1;
        check("sticky_set", 76'({sticky_ovf, sticky_brw}), 76'b11);
        repeat (2) @(negedge clk);
        #1;
        check("sticky_persist", 76'({sticky_ovf, sticky_brw}), 76'b11);
        flag_clr = 1;
        @(negedge clk);
        flag_clr = 0;
        #1;
        check("sticky_clr", 76'({sticky_ovf, sticky_brw}), 76'b00);
        drive_op(mk(FN_ADD, TYPE_R), 32'h7FFFFFFF, 1, 0, 0, 0);
        in_valid = 1;
        @(negedge clk);
        in_valid = 0; flag_clr = 1;
        @(negedge clk);
        flag_clr = 0;
        #1;
        check("sticky_set_wins", 76'({sticky_ovf, sticky_brw}), 76'b10);

        // Backpressure: two ops held, third stalled, then in-order drain
        @(negedge clk);
        fill(3, idx);
        check("bp_accepts", 76'(idx), 76'd2);
        drive_op(mk(FN_ADD, TYPE_R), 3, 3, 2, 32'h200, 0);
        in_valid = 1;
        #1;
        check("bp_in_ready_low", 76'(in_ready), 76'd0);
        check("bp_stable_out", 76'({out_valid, out_result}), {44'd1, 32'd2});
        @(negedge clk);
        out_ready = 1;
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (idx < 3) begin
                drive_op(mk(FN_ADD, TYPE_R), idx + 1, idx + 1, 5'(idx), 32'h200, 0);
                in_valid = 1;
            end else in_valid = 0;
            #1;
            acc = int'(in_valid && in_ready);
            if (out_valid && out_ready) begin res[got] = out_result; got++; end
            @(posedge clk);
            idx += acc;
            @(negedge clk);
        end
        in_valid = 0;
        check("bp_count", 76'(got), 76'd3);
        for (int k = 0; k < 3; k++) check($sformatf("bp_result%0d", k), 76'(res[k]), 76'(2 * (k + 1)));
        #1;
`ifdef ALU_ISSUE_PERF_EN
        check("cnt_ops_dir", 76'(cnt_ops), 76'(seen_ops));
        check("cnt_taken_dir", 76'(cnt_taken), 76'd3);
`else
        check("cnt_ops_dir", 76'({cnt_ops, cnt_taken}), 76'd0);
`endif

        // Flush with both stages full; op offered in the flush cycle is refused
        @(negedge clk);
        fill(2, idx);
        #1;
        check("fl_full", 76'({out_valid, in_ready}), 76'b10);
        flush = 1; in_valid = 1;
        drive_op(mk(FN_ADD, TYPE_R), 9, 9, 1, 0, 0);
        #1;
        check("fl_in_ready", 76'(in_ready), 76'd0);
        @(negedge clk);
        flush = 0; in_valid = 0;
        #1;
        check("fl_after", 76'({out_valid, in_ready}), 76'b01);
        out_ready = 1;
        hits = 0;
        for (int c = 0; c < 5; c++) begin @(negedge clk); #1; if (out_valid) hits++; end
        check("fl_no_output", 76'(hits), 76'd0);

        // Randomized traffic against the reference model
        exp_q.delete();
        pending = 0;
        @(negedge clk);
        for (int c = 0; c < 600; c++) begin
            if (!pending) begin
                case ($urandom_range(0, 4))
                    0, 1: rop = mk(4'($urandom_range(0, 6)), TYPE_R);
                    2, 3: rop = mk(4'($urandom_range(0, 4)), TYPE_B);
                    default: rop = mk(4'($urandom_range(0, 15)), 3'($urandom_range(3, 7)));
                endcase
                ra = $urandom;
                rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                if ($urandom_range(0, 3) == 0) ra = 32'h7FFFFFF0 + 32'($urandom_range(0, 31));
                rrd = 5'($urandom); rpc = $urandom; rimm = $urandom;
                drive_op(rop, ra, rb, rrd, rpc, rimm);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) exp_q.push_back(model(rop, ra, rb, rrd, rpc, rimm));
            pending = in_valid && !in_ready;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("rnd_unexpected", dut_bundle(), 76'd0);
                else check($sformatf("rnd%0d", c), dut_bundle(), exp_q.pop_front());
            end
            @(posedge clk); @(negedge clk);
        end
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid && exp_q.size() != 0) check("rnd_drain", dut_bundle(), exp_q.pop_front());
            @(negedge clk);
        end
        check("rnd_queue_empty", 76'(exp_q.size()), 76'd0);
        #1;
`ifdef ALU_ISSUE_PERF_EN
        check("cnt_ops_rnd", 76'({cnt_ops, cnt_taken}), 76'({32'(seen_ops), 32'(seen_taken)}));
`else
        check("cnt_ops_rnd", 76'({cnt_ops, cnt_taken}), 76'd0);
`endif

        // Asynchronous reset with two ops in flight
        @(negedge clk);
        fill(2, idx);
        #1;
        check("rst_full", 76'(out_valid), 76'd1);
        #2 rst_n = 0;
        #1;
        check("rst_async_ctl", 76'({in_ready, out_valid, sticky_ovf, sticky_brw}), 76'd0);
        check("rst_async_out", dut_bundle(), 76'd0);
        check("rst_async_cnt", 76'({cnt_ops, cnt_taken}), 76'd0);
        @(negedge clk);
        rst_n = 1; out_ready = 1;
        hits = 0;
        for (int c = 0; c < 5; c++) begin #1; if (out_valid) hits++; @(negedge clk); end
        check("rst_no_stale", 76'(hits), 76'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
